// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: turns single-word read/write requests into
// opcode + address + data frames with a valid/ready request side and a response pulse.
module spi_mem_ctrl #(
    parameter int         ADDR_W      = 16,
    parameter int         ADDR_BYTES  = 2,
    parameter int         DATA_W      = 16,
    parameter int         HALF_PERIOD = 1,
    parameter int         CS_GAP      = 1,
    parameter logic [7:0] CMD_READ    = 8'h03,
    parameter logic [7:0] CMD_WRITE   = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_select,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int NB = DATA_W / 8;
    localparam int N  = 8 + AW + DATA_W;
    localparam int BW = $clog2(N + 1);
    localparam int DW = $clog2(HALF_PERIOD + 1);
    localparam int GW = $clog2(CS_GAP + 1);

    localparam logic [BW-1:0] CMD_LAST  = BW'(7);
    localparam logic [BW-1:0] ADDR_LAST = BW'(8 + AW - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP
    } state_t;

    // The wire carries data bytes lowest address first, so both directions reverse byte order.
    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = w[8*(NB-1-i) +: 8];
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              cs_q, cs_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [N-1:0]      sh_q, sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N-1:0]      frame;

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign spi_select = cs_q;
    assign spi_clk    = sck_q;
    assign spi_mosi   = mosi_q;

    always_comb begin
        state_d     = state_q;
        cs_d        = cs_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        wr_d        = wr_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        frame       = {(req_write ? CMD_WRITE : CMD_READ), AW'(req_addr),
                       (req_write ? byte_swap(req_wdata) : {DATA_W{1'b0}})};

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d   = S_CMD;
                    cs_d      = 1'b0;
                    sck_d     = 1'b0;
                    mosi_d    = frame[N-1];
                    sh_d      = {frame[N-2:0], 1'b0};
                    div_d     = '0;
                    bit_cnt_d = '0;
                    wr_d      = req_write;
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[DATA_W-2:0], spi_miso};
                        end
                    end else begin
                        // End of a bit: SCK falls and MOSI advances in the same edge.
                        sck_d = 1'b0;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d     = S_GAP;
                            cs_d        = 1'b1;
                            mosi_d      = 1'b0;
                            gap_d       = '0;
                            rsp_valid_d = 1'b1;
                            if (!wr_q) begin
                                rdata_d = byte_swap(rx_q);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            mosi_d    = sh_q[N-1];
                            sh_d      = {sh_q[N-2:0], 1'b0};
                            if (bit_cnt_q == CMD_LAST) begin
                                state_d = S_ADDR;
                            end else if (bit_cnt_q == ADDR_LAST) begin
                                state_d = S_DATA;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
        sh_q <= sh_d;
        rx_q <= rx_d;
        wr_q <= wr_d;
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: default-parameter instance plus a DATA_W=8 / 3-byte address /
// HALF_PERIOD=2 instance, checked against a byte-level frame model.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, rsp_valid, busy, spi_select, spi_clk, spi_mosi;
    logic [15:0] rsp_rdata;
    logic        spi_miso = 1'b0;

    logic        req_valid1 = 1'b0;
    logic        req_write1 = 1'b0;
    logic [15:0] req_addr1  = '0;
    logic [7:0]  req_wdata1 = '0;
    logic        req_ready1, rsp_valid1, busy1, sel1, sck1, mosi1;
    logic [7:0]  rsp_rdata1;
    logic        miso1 = 1'b0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    spi_mem_ctrl dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    spi_mem_ctrl #(.ADDR_W(16), .ADDR_BYTES(3), .DATA_W(8), .HALF_PERIOD(2), .CS_GAP(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
        .spi_select(sel1), .spi_clk(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    // Observation state for the default instance, updated on the falling edge.
    int          cyc = 0, acc_n = 0, acc_cyc = 0, frise = 0;
    int          rsp_n = 0, rsp_cyc = 0, cs_fall_cyc = 0, rdy_cyc = 0, hi_run = 0;
    int          busy_viol = 0, mosi_viol = 0;
    logic [63:0] fbits = '0;
    logic [39:0] frames[$];
    int          frises[$];
    int          gaps[$];
    logic [15:0] rsp_data[$];
    logic [15:0] resp_word = '0;
    logic        cs_prev = 1'b1, sck_prev = 1'b0, mosi_prev = 1'b0, rdy_prev = 1'b0;

    always @(negedge clk) begin : mon0
        int k;
        cyc++;
        if (req_valid && req_ready) begin
            acc_n++;
            acc_cyc = cyc;
            frise   = 0;
        end
        if (spi_clk && !sck_prev) begin
            frise++;
            fbits = {fbits[62:0], spi_mosi};
        end
        if (spi_clk && (spi_mosi !== mosi_prev)) mosi_viol++;
        if (spi_select && !cs_prev) begin
            frames.push_back(fbits[39:0]);
            frises.push_back(frise);
            fbits = '0;
        end
        if (!spi_select && cs_prev) begin
            cs_fall_cyc = cyc;
            gaps.push_back(hi_run);
        end
        hi_run = spi_select ? hi_run + 1 : 0;
        if (rsp_valid) begin
            rsp_n++;
            rsp_cyc = cyc;
            rsp_data.push_back(rsp_rdata);
        end
        if (req_ready && !rdy_prev) rdy_cyc = cyc;
        if (!spi_select && !busy) busy_viol++;
        // Memory model: present the response byte stream, lowest byte first, MSB first.
        if (!spi_select && !spi_clk) begin
            k = frise - 24;
            spi_miso = (k >= 0 && k < 16) ? resp_word[8*(k/8) + 7 - (k%8)]
                                          : 1'($urandom_range(0, 1));
        end
        cs_prev   = spi_select;
        sck_prev  = spi_clk;
        mosi_prev = spi_mosi;
        rdy_prev  = req_ready;
    end

    // Observation state for the parameterised instance.
    int          cyc1 = 0, acc1_n = 0, acc1_cyc = 0, rise1 = 0, rsp1_n = 0, rsp1_cyc = 0;
    int          run1 = 0, bad1 = 0;
    logic [39:0] fb1 = '0, frame1 = '0;
    logic        sel1_prev = 1'b1, sck1_prev = 1'b0;

    always @(negedge clk) begin : mon1
        cyc1++;
        if (req_valid1 && req_ready1) begin
            acc1_n++;
            acc1_cyc = cyc1;
            rise1    = 0;
        end
        if (sck1 && !sck1_prev) begin
            rise1++;
            fb1 = {fb1[38:0], mosi1};
        end
        if (!sel1) begin
            if (sel1_prev) run1 = 1;
            else if (sck1 == sck1_prev) run1++;
            else begin
                if (run1 != 2) bad1++;
                run1 = 1;
            end
        end else if (!sel1_prev) begin
            if (run1 != 2) bad1++;
            frame1 = fb1;
            fb1    = '0;
        end
        if (rsp_valid1) begin
            rsp1_n++;
            rsp1_cyc = cyc1;
        end
        sel1_prev = sel1;
        sck1_prev = sck1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: opcode, address bytes high to low, then data bytes low to high.
    function automatic logic [39:0] exp_frame0(input bit wr, input logic [15:0] a,
                                               input logic [15:0] d);
        logic [7:0]  bytes[5];
        logic [39:0] r;
        bytes[0] = wr ? 8'h02 : 8'h03;
        bytes[1] = a[15:8];
        bytes[2] = a[7:0];
        bytes[3] = wr ? d[7:0] : 8'h00;
        bytes[4] = wr ? d[15:8] : 8'h00;
        r = '0;
        for (int i = 0; i < 5; i++) r = {r[31:0], bytes[i]};
        return r;
    endfunction

    logic [15:0] last_rd = '0;

    task automatic issue0(input bit wr, input logic [15:0] a, input logic [15:0] d);
        int target;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        target = acc_n + 1;
        for (int i = 0; i < 300 && acc_n < target; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        chk("accept_timeout", 64'(acc_n >= target), 1);
    endtask

    task automatic run_txn0(input bit wr, input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] resp, input bit toggle);
        int r0;
        resp_word = resp;
        r0 = rsp_n;
        issue0(wr, a, d);
        for (int i = 0; i < 400 && rsp_n <= r0; i++) begin
            @(posedge clk);
            #1;
            if (toggle) begin
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
                req_write = 1'($urandom_range(0, 1));
            end
        end
        chk("rsp_timeout", 64'(rsp_n > r0), 1);
        chk("rsp_latency", 64'(rsp_cyc - acc_cyc), 81);
        chk("mosi_frame", frames[frames.size()-1], exp_frame0(wr, a, d));
        chk("sck_rises", 64'(frises[frises.size()-1]), 40);
        if (!wr) last_rd = resp;
        chk("rsp_rdata", rsp_data[rsp_data.size()-1], last_rd);
    endtask

    initial begin : stim
        int          r0, a0;
        bit          bw[3];
        logic [15:0] ba[3], bd[3];
        logic [15:0] rv;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {spi_select, spi_clk, spi_mosi, rsp_valid, busy, req_ready}, 6'b100000);
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_ready1", req_ready1, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Default write with exact timing
        run_txn0(1'b1, 16'h1234, 16'hBEEF, 16'h0000, 1'b0);
        chk("cs_fall", 64'(cs_fall_cyc - acc_cyc), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("ready_return", 64'(rdy_cyc - acc_cyc), 82);
        chk("idle_after", {busy, req_ready, spi_select}, 3'b011);

        // Default read, memory returns 5A then C3
        run_txn0(1'b0, 16'h00FF, 16'hFFFF, 16'hC35A, 1'b0);
        chk("read_word", last_rd, 16'hC35A);

        // Back-to-back alternating requests with req_valid held high
        gaps.delete();
        r0 = rsp_n;
        a0 = acc_n;
        resp_word = 16'($urandom);
        for (int j = 0; j < 3; j++) begin
            bw[j] = (j != 1);
            ba[j] = 16'($urandom);
            bd[j] = 16'($urandom);
        end
        req_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            req_write = bw[j];
            req_addr  = ba[j];
            req_wdata = bd[j];
            for (int i = 0; i < 300 && acc_n < a0 + j + 1; i++) begin
                @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 400 && rsp_n < r0 + 3; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_rsp_count", 64'(rsp_n - r0), 3);
        chk("b2b_gap_count", 64'(gaps.size()), 3);
        chk("b2b_gap1", 64'(gaps[1]), 2);
        chk("b2b_gap2", 64'(gaps[2]), 2);
        for (int j = 0; j < 3; j++) begin
            chk("b2b_frame", frames[frames.size()-3+j], exp_frame0(bw[j], ba[j], bd[j]));
        end
        last_rd = resp_word;
        chk("b2b_rdata_read", rsp_data[rsp_data.size()-2], last_rd);
        chk("b2b_rdata_hold", rsp_data[rsp_data.size()-1], last_rd);

        // Reset in the middle of the address phase
        r0 = rsp_n;
        issue0(1'b1, 16'hA55A, 16'h0F0F);
        for (int i = 0; i < 200 && frise < 12; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_edge12", 64'(frise), 12);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_in_rst", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("pins_after_rst", {spi_select, spi_clk, spi_mosi, busy}, 4'b1000);
        chk("ready_after_rst", req_ready, 1);
        repeat (100) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 64'(rsp_n), 64'(r0));
        last_rd = 16'h0000;
        run_txn0(1'b0, 16'h4321, 16'h0000, 16'h9E17, 1'b0);

        // Request inputs changing while a frame is in flight
        run_txn0(1'b1, 16'h5AA5, 16'h3C96, 16'h0000, 1'b1);
        run_txn0(1'b0, 16'hC001, 16'h1111, 16'h7E81, 1'b1);

        // Randomized transactions
        for (int n = 0; n < 6; n++) begin
            rv = 16'($urandom);
            run_txn0(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), rv, 1'($urandom_range(0, 1)));
        end

        // Parameterised instance: 8-bit data, 3 address bytes, HALF_PERIOD=2
        req_write1 = 1'b1;
        req_addr1  = 16'hBEEF;
        req_wdata1 = 8'hA5;
        req_valid1 = 1'b1;
        for (int i = 0; i < 300 && acc1_n < 1; i++) begin
            @(posedge clk);
            #1;
        end
        req_valid1 = 1'b0;
        req_addr1  = 16'h0000;
        req_wdata1 = 8'h00;
        for (int i = 0; i < 400 && rsp1_n < 1; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("p_rsp_count", 64'(rsp1_n), 1);
        chk("p_frame", frame1, {8'h02, 8'h00, 8'hBE, 8'hEF, 8'hA5});
        chk("p_rises", 64'(rise1), 40);
        chk("p_latency", 64'(rsp1_cyc - acc1_cyc), 161);
        chk("p_sck_runs", 64'(bad1), 0);
        chk("p_idle", {busy1, req_ready1, sel1}, 3'b011);
        chk("p_rdata_hold", rsp_rdata1, 0);

        chk("mosi_stable_sck_high", 64'(mosi_viol), 0);
        chk("busy_during_frame", 64'(busy_viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
